uart_miner_ctrl: RTL and testbench
==================================

UART_MINER_CTRL -- requirements
Module: uart_miner_ctrl

Interface
REQ-001 Parameter HEADER_BYTES, default 80, header length in bytes; header_data width is 8*HEADER_BYTES.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000000, inter-byte idle limit before a partial header is discarded.
REQ-003 clock  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_rdy  input  1  UART receiver byte-ready flag; held high until cleared.
REQ-006 rx_data  input  8  UART received byte, valid while rx_rdy=1.
REQ-007 rx_rdy_clr  output  1  one-cycle clear pulse to the UART receiver.
REQ-008 tx_busy  input  1  UART transmitter busy flag.
REQ-009 tx_data  output  8  byte to transmit.
REQ-010 tx_wr_en  output  1  one-cycle write strobe to the UART transmitter.
REQ-011 nonce_valid  input  1  miner has a winning nonce; held until nonce_ack.
REQ-012 nonce  input  32  winning nonce, valid with nonce_valid.
REQ-013 nonce_ack  output  1  one-cycle pulse; nonce latched.
REQ-014 header_data  output  640  last complete header, first received byte in bits [639:632].
REQ-015 header_valid  output  1  one-cycle pulse; header_data updated.
REQ-016 rx_count  output  7  bytes received toward the current header.
REQ-017 tx_active  output  1  high whenever the TX state machine is not IDLE.

Function
REQ-018 RX capture: when rx_rdy=1 and rx_rdy_clr=0, shift rx_data into the internal assembly buffer LSB end, increment rx_count, and assert rx_rdy_clr the next cycle for exactly one cycle.
REQ-019 The byte arriving with rx_count=HEADER_BYTES-1 completes a header: next cycle, copy the buffer to header_data, pulse header_valid, set rx_count=0, set ack_pending.
REQ-020 header_data changes only on header completion; partial headers are never visible.
REQ-021 Timeout: rx_count>0 and TIMEOUT_CYCLES clocks with no captured byte -> rx_count=0, buffer discarded, header_data unchanged, no header_valid.
REQ-022 TX states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-023 IDLE: leave only when tx_busy=0; if ack_pending=1, select ack frame (1 byte 0x41) and clear ack_pending; else if nonce_valid=1, latch nonce, pulse nonce_ack, select nonce frame (5 bytes: 0x4E, nonce[31:24], [23:16], [15:8], [7:0]); go to LOAD.
REQ-024 Ack has priority over nonce when both are pending in the same IDLE cycle.
REQ-025 LOAD: drive tx_data with the current frame byte, assert tx_wr_en for one cycle, go to WAIT_BUSY.
REQ-026 WAIT_BUSY: stay until tx_busy=1, then WAIT_DONE; WAIT_DONE: stay until tx_busy=0, then LOAD if bytes remain, else IDLE.
REQ-027 Exactly one tx_wr_en pulse per frame byte; tx_data stable from LOAD until the next LOAD.
REQ-028 nonce_valid asserted while not IDLE is not acknowledged; it is serviced at the next IDLE.
REQ-029 Header completion during a TX frame sets ack_pending; current frame completes unaltered.
REQ-030 Header completion while ack_pending=1 leaves ack_pending=1 (one ack sent).
REQ-031 Latched nonce is not affected by nonce input changes during the frame.
REQ-032 RX and TX paths operate concurrently and independently.

Reset
REQ-033 reset=0 asynchronously forces: TX state IDLE, rx_count=0, ack_pending=0, timeout counter 0, header_data=0, buffer=0, tx_data=0, and rx_rdy_clr, tx_wr_en, nonce_ack, header_valid, tx_active all 0.
REQ-034 Reset mid-frame aborts the frame; no further tx_wr_en until a new request after release.

Verification
REQ-035 80 bytes 0x00..0x4F via rx_rdy handshake -> one rx_rdy_clr per byte; header_valid once; header_data[639:632]=0x00, [7:0]=0x4F; then tx_wr_en with tx_data=0x41.
REQ-036 nonce_valid with nonce=0x12345678, UART model busy 10 cycles per byte -> nonce_ack once; tx_data sequence 0x4E,0x12,0x34,0x56,0x78; five tx_wr_en pulses, each after tx_busy fell.
REQ-037 Header completes and nonce_valid rises in the same IDLE cycle -> 0x41 sent first, then the nonce frame.
REQ-038 40 bytes, then TIMEOUT_CYCLES (set to 100) idle -> rx_count=0, no header_valid, header_data unchanged; next 80 bytes form a correct header.
REQ-039 reset=0 during third byte of nonce frame -> all outputs 0 immediately; after release no tx_wr_en without a new request.

Source files
------------

// File: rtl/uart_miner_ctrl.sv
// Purpose: UART front-end for a miner; assembles block headers from RX bytes, sends ack/nonce frames on TX.
// Latency: header_valid and rx_rdy_clr one cycle after the final byte is seen; first tx_wr_en two cycles after a request is taken.
// Backpressure: one RX byte per rx_rdy/rx_rdy_clr handshake; TX paced by tx_busy, requests wait in IDLE.
module uart_miner_ctrl #(
  parameter int HEADER_BYTES   = 80,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_rdy,
  input  logic [7:0]                rx_data,
  output logic                      rx_rdy_clr,
  input  logic                      tx_busy,
  output logic [7:0]                tx_data,
  output logic                      tx_wr_en,
  input  logic                      nonce_valid,
  input  logic [31:0]               nonce,
  output logic                      nonce_ack,
  output logic [8*HEADER_BYTES-1:0] header_data,
  output logic                      header_valid,
  output logic [6:0]                rx_count,
  output logic                      tx_active
);

  localparam int HW   = 8 * HEADER_BYTES;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } tx_state_t;

  // RX path state
  logic [HW-1:0]   buf_q, buf_d;
  logic [HW-1:0]   hdr_q, hdr_d;
  logic            hdr_vld_q, hdr_vld_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            clr_q, clr_d;
  logic [TO_W-1:0] idle_q, idle_d;
  logic            capture;
  logic            complete;

  // TX path state
  tx_state_t       st_q, st_d;
  logic [39:0]     frame_q, frame_d;
  logic [2:0]      left_q, left_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            wr_q, wr_d;
  logic            nack_q, nack_d;
  logic            ack_pend_q, ack_pend_d;
  logic            ack_take;

  // A byte is taken only when the previous clear pulse is not still in flight.
  assign capture = rx_rdy && !clr_q;

  // RX assembly: shift bytes in, publish full headers, drop stale partial headers.
  always_comb begin
    buf_d     = buf_q;
    hdr_d     = hdr_q;
    hdr_vld_d = 1'b0;
    cnt_d     = cnt_q;
    clr_d     = 1'b0;
    idle_d    = idle_q;
    complete  = 1'b0;
    if (capture) begin
      clr_d  = 1'b1;
      idle_d = '0;
      if (cnt_q == 7'(HEADER_BYTES - 1)) begin
        // Final byte goes straight into the published header; buffer restarts empty.
        complete  = 1'b1;
        hdr_d     = {buf_q[HW-9:0], rx_data};
        hdr_vld_d = 1'b1;
        buf_d     = '0;
        cnt_d     = '0;
      end else begin
        buf_d = {buf_q[HW-9:0], rx_data};
        cnt_d = cnt_q + 7'd1;
      end
    end else if (cnt_q != 7'd0) begin
      if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        cnt_d  = '0;
        buf_d  = '0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + TO_W'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  // RX registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q     <= '0;
      hdr_q     <= '0;
      hdr_vld_q <= 1'b0;
      cnt_q     <= '0;
      clr_q     <= 1'b0;
      idle_q    <= '0;
    end else begin
      buf_q     <= buf_d;
      hdr_q     <= hdr_d;
      hdr_vld_q <= hdr_vld_d;
      cnt_q     <= cnt_d;
      clr_q     <= clr_d;
      idle_q    <= idle_d;
    end
  end

  // TX sequencer: pick a frame in IDLE (ack first), then one write per byte paced by tx_busy.
  always_comb begin
    st_d      = st_q;
    frame_d   = frame_q;
    left_d    = left_q;
    tx_data_d = tx_data_q;
    wr_d      = 1'b0;
    nack_d    = 1'b0;
    ack_take  = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (!tx_busy) begin
          if (ack_pend_q) begin
            ack_take = 1'b1;
            frame_d  = {8'h41, 32'h0};
            left_d   = 3'd1;
            st_d     = S_LOAD;
          end else if (nonce_valid) begin
            nack_d  = 1'b1;
            frame_d = {8'h4E, nonce};
            left_d  = 3'd5;
            st_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        // tx_data holds this byte until the next LOAD.
        tx_data_d = frame_q[39:32];
        frame_d   = {frame_q[31:0], 8'h00};
        left_d    = left_q - 3'd1;
        wr_d      = 1'b1;
        st_d      = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) st_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) st_d = (left_q != 3'd0) ? S_LOAD : S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
    // A new completion always leaves an ack owed; repeated completions collapse to one.
    ack_pend_d = (ack_pend_q && !ack_take) || complete;
  end

  // TX registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= S_IDLE;
      frame_q    <= '0;
      left_q     <= '0;
      tx_data_q  <= '0;
      wr_q       <= 1'b0;
      nack_q     <= 1'b0;
      ack_pend_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      frame_q    <= frame_d;
      left_q     <= left_d;
      tx_data_q  <= tx_data_d;
      wr_q       <= wr_d;
      nack_q     <= nack_d;
      ack_pend_q <= ack_pend_d;
    end
  end

  assign rx_rdy_clr   = clr_q;
  assign header_data  = hdr_q;
  assign header_valid = hdr_vld_q;
  assign rx_count     = cnt_q;
  assign tx_data      = tx_data_q;
  assign tx_wr_en     = wr_q;
  assign nonce_ack    = nack_q;
  assign tx_active    = (st_q != S_IDLE);

endmodule

// File: tb/tb_uart_miner_ctrl.sv
// Purpose: self-checking bench for uart_miner_ctrl with UART RX/TX models and a header/frame reference model.
// Latency: n/a (testbench).
// Backpressure: TX model holds tx_busy for a fixed number of cycles per written byte.
module tb_uart_miner_ctrl;
  localparam int HB       = 80;
  localparam int HW       = 8 * HB;
  localparam int TO       = 100;
  localparam int BUSY_LEN = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_rdy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_rdy_clr;
  logic          tx_busy = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_wr_en;
  logic          nonce_valid = 1'b0;
  logic [31:0]   nonce = 32'h0;
  logic          nonce_ack;
  logic [HW-1:0] header_data;
  logic          header_valid;
  logic [6:0]    rx_count;
  logic          tx_active;

  int checks = 0;
  int failures = 0;
  int cnt_clr = 0, cnt_hv = 0, cnt_nack = 0, wr_busy = 0, busy_cnt = 0;
  logic [7:0] tx_q[$];
  logic [7:0] hb[HB];

  typedef struct {
    logic [31:0] n;
    logic [39:0] frame;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  uart_miner_ctrl #(.HEADER_BYTES(HB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_rdy_clr(rx_rdy_clr),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_wr_en(tx_wr_en),
    .nonce_valid(nonce_valid), .nonce(nonce), .nonce_ack(nonce_ack),
    .header_data(header_data), .header_valid(header_valid),
    .rx_count(rx_count), .tx_active(tx_active)
  );

  // Pulse counters plus UART transmitter model: busy for BUSY_LEN cycles after each write.
  always @(negedge clk) begin
    if (rx_rdy_clr) cnt_clr++;
    if (header_valid) cnt_hv++;
    if (nonce_ack) cnt_nack++;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
    if (tx_wr_en) begin
      if (tx_busy) wr_busy++;
      tx_q.push_back(tx_data);
      tx_busy  = 1'b1;
      busy_cnt = BUSY_LEN;
    end
  end

  task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Header as the bytes would appear in order, first byte in the top bits.
  function automatic logic [HW-1:0] model_hdr();
    logic [HW-1:0] r;
    r = '0;
    for (int i = 0; i < HB; i++) r[HW-1-8*i -: 8] = hb[i];
    return r;
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rx_rdy_clr"}, rx_rdy_clr, 0);
    chk({tag, "_tx_wr_en"}, tx_wr_en, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_nonce_ack"}, nonce_ack, 0);
    chk({tag, "_header_valid"}, header_valid, 0);
    chk({tag, "_header_data"}, header_data, 0);
    chk({tag, "_rx_count"}, rx_count, 0);
    chk({tag, "_tx_active"}, tx_active, 0);
  endtask

  // UART receiver model: present a byte, hold it until the clear pulse arrives.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rx_rdy_clr && k < 20);
    chk("rx_clr_seen", rx_rdy_clr, 1);
    rx_rdy = 1'b0;
  endtask

  task automatic send_hb(input int max_gap, input int count);
    for (int i = 0; i < count; i++) send_byte(hb[i], $urandom_range(0, max_gap));
  endtask

  task automatic req_nonce(input logic [31:0] n);
    int k;
    @(negedge clk);
    nonce       = n;
    nonce_valid = 1'b1;
    k = 0;
    while (!nonce_ack && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("nonce_ack_seen", nonce_ack, 1);
    nonce_valid = 1'b0;
    nonce       = $urandom;
  endtask

  task automatic wait_tx(input int target);
    int k;
    k = 0;
    while ((tx_q.size() < target || tx_active || tx_busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("tx_complete", (tx_q.size() >= target) ? 1 : 0, 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int base, h0, n0, c0, k;
    logic [31:0] rn;
    logic [39:0] f;
    logic [HW-1:0] prev;

    vecs[0] = '{32'h12345678, 40'h4E12345678};
    vecs[1] = '{32'h00000000, 40'h4E00000000};
    vecs[2] = '{32'hFFFFFFFF, 40'h4EFFFFFFFF};
    vecs[3] = '{32'h4E41A55A, 40'h4E4E41A55A};

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Incrementing header, then its ack frame
    for (int i = 0; i < HB; i++) hb[i] = 8'(i);
    c0 = cnt_clr; h0 = cnt_hv; base = tx_q.size();
    send_hb(0, HB);
    chk("hdr_valid_pulse", header_valid, 1);
    repeat (2) @(negedge clk);
    chk("hdr_clr_count", cnt_clr - c0, HB);
    chk("hdr_valid_once", cnt_hv - h0, 1);
    chk("hdr_first_byte", header_data[HW-1 -: 8], 8'h00);
    chk("hdr_last_byte", header_data[7:0], 8'h4F);
    chk("hdr_full", header_data, model_hdr());
    chk("rx_count_zero", rx_count, 0);
    wait_tx(base + 1);
    chk("ack_len", tx_q.size() - base, 1);
    chk("ack_byte", tx_q[base], 8'h41);

    // Table of nonce frames
    for (int v = 0; v < 4; v++) begin
      base = tx_q.size(); n0 = cnt_nack;
      req_nonce(vecs[v].n);
      wait_tx(base + 5);
      f = vecs[v].frame;
      for (int i = 0; i < 5; i++) chk("nonce_frame_byte", tx_q[base + i], f[39-8*i -: 8]);
      chk("nonce_frame_len", tx_q.size() - base, 5);
      chk("nonce_ack_once", cnt_nack - n0, 1);
    end

    // Header completion and nonce request in the same IDLE cycle: ack goes first
    for (int i = 0; i < HB; i++) hb[i] = 8'($urandom);
    send_hb(1, HB - 1);
    base = tx_q.size(); n0 = cnt_nack;
    @(negedge clk);
    rx_data = hb[HB-1];
    rx_rdy  = 1'b1;
    k = 0;
    while (!header_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("race_hv_seen", header_valid, 1);
    rx_rdy      = 1'b0;
    nonce       = 32'hCAFEF00D;
    nonce_valid = 1'b1;
    k = 0;
    while (!nonce_ack && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("race_nonce_ack", nonce_ack, 1);
    nonce_valid = 1'b0;
    nonce       = 32'h0BADBEEF;
    wait_tx(base + 6);
    f = 40'h4ECAFEF00D;
    chk("race_first_ack", tx_q[base], 8'h41);
    for (int i = 0; i < 5; i++) chk("race_nonce_byte", tx_q[base + 1 + i], f[39-8*i -: 8]);
    chk("race_len", tx_q.size() - base, 6);
    chk("race_hdr", header_data, model_hdr());
    chk("race_nack_once", cnt_nack - n0, 1);

    // Partial header times out without disturbing the published header
    prev = header_data; h0 = cnt_hv;
    for (int i = 0; i < 40; i++) hb[i] = 8'($urandom);
    send_hb(2, 40);
    chk("to_partial_count", rx_count, 40);
    repeat (90) @(negedge clk);
    chk("to_before_expiry", rx_count, 40);
    repeat (15) @(negedge clk);
    chk("to_after_expiry", rx_count, 0);
    chk("to_no_hv", cnt_hv - h0, 0);
    chk("to_hdr_kept", header_data, prev);
    for (int i = 0; i < HB; i++) hb[i] = 8'($urandom);
    base = tx_q.size(); h0 = cnt_hv;
    send_hb(3, HB);
    repeat (2) @(negedge clk);
    chk("to_next_hdr", header_data, model_hdr());
    chk("to_next_hv_once", cnt_hv - h0, 1);
    wait_tx(base + 1);
    chk("to_next_ack", tx_q[base], 8'h41);

    // Randomized headers and nonces against the model
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < HB; i++) hb[i] = 8'($urandom);
      h0 = cnt_hv; base = tx_q.size();
      send_hb(5, HB);
      repeat (2) @(negedge clk);
      chk("rand_hdr", header_data, model_hdr());
      chk("rand_hv_once", cnt_hv - h0, 1);
      wait_tx(base + 1);
      chk("rand_ack_byte", tx_q[base], 8'h41);
      rn = $urandom;
      base = tx_q.size(); n0 = cnt_nack;
      req_nonce(rn);
      wait_tx(base + 5);
      f = {8'h4E, rn};
      for (int i = 0; i < 5; i++) chk("rand_nonce_byte", tx_q[base + i], f[39-8*i -: 8]);
      chk("rand_nack_once", cnt_nack - n0, 1);
    end

    // Reset during the third byte of a nonce frame
    base = tx_q.size();
    req_nonce(32'hA1B2C3D4);
    k = 0;
    while (tx_q.size() < base + 3 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("rst_third_byte", (tx_q.size() >= base + 3) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("rst_no_more_wr", tx_q.size() - base, 3);
    chk("rst_tx_idle", tx_active, 0);
    base = tx_q.size();
    req_nonce(32'h01020304);
    wait_tx(base + 5);
    f = 40'h4E01020304;
    for (int i = 0; i < 5; i++) chk("post_rst_byte", tx_q[base + i], f[39-8*i -: 8]);

    chk("wr_while_busy", wr_busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
